// File: rtl/trigger_edge_detector.sv
// Trigger edge detector: pre-trigger fill, armed rising-crossing wait, post-trigger capture, done.
// Optional macro TRIGGER_AUTO_EN forces a trigger after AUTO_TIMEOUT armed samples.
module trigger_edge_detector #(
    parameter int BITS_ADC     = 8,
    parameter int BUF_ADDR_W   = 12,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [BUF_ADDR_W-1:0] pretrigger_samples,
    input  logic [BUF_ADDR_W-1:0] num_samples,
    input  logic [BITS_ADC-1:0]   trigger_value_in,
    input  logic [BITS_ADC-1:0]   trigger_source_in,
    input  logic                  trigger_source_rdy,
    output logic                  buffer_wr_en,
    output logic [BUF_ADDR_W-1:0] wr_addr,
    output logic [BUF_ADDR_W-1:0] trigger_addr,
    output logic                  triggered,
    output logic                  auto_triggered,
    output logic                  running,
    output logic                  done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [BUF_ADDR_W-1:0] ADDR_ZERO = {BUF_ADDR_W{1'b0}};
    localparam logic [BUF_ADDR_W-1:0] ADDR_ONE  = {{(BUF_ADDR_W-1){1'b0}}, 1'b1};

    if (AUTO_TIMEOUT < 1) begin : g_bad_timeout
        $error("AUTO_TIMEOUT must be at least 1");
    end

    // Post length counts the trigger sample; a zero total is treated as one sample.
    function automatic logic [BUF_ADDR_W-1:0] calc_post_len(
        input logic [BUF_ADDR_W-1:0] pre_len,
        input logic [BUF_ADDR_W-1:0] total_len
    );
        logic [BUF_ADDR_W-1:0] total_eff;
        total_eff = (total_len == ADDR_ZERO) ? ADDR_ONE : total_len;
        if (total_eff > pre_len) begin
            calc_post_len = total_eff - pre_len;
        end else begin
            calc_post_len = ADDR_ONE;
        end
    endfunction

    state_t                state_r;
    state_t                seq_s;
    state_t                state_s;
    logic [BUF_ADDR_W-1:0] pre_len_r;
    logic [BUF_ADDR_W-1:0] post_len_r;
    logic [BUF_ADDR_W-1:0] pre_cnt_r;
    logic [BUF_ADDR_W-1:0] post_cnt_r;
    logic [BUF_ADDR_W-1:0] wr_addr_r;
    logic [BUF_ADDR_W-1:0] trigger_addr_r;
    logic [BITS_ADC-1:0]   value_r;
    logic [BITS_ADC-1:0]   prev_r;
    logic                  prev_valid_r;
    logic                  triggered_r;
    logic                  active_s;
    logic                  sample_s;
    logic                  track_s;
    logic                  crossing_s;
    logic                  timeout_s;
    logic                  fire_s;
    logic                  pre_last_s;
    logic                  post_last_s;

    assign active_s    = (state_r == ST_PRE) || (state_r == ST_ARMED) || (state_r == ST_POST);
    assign sample_s    = trigger_source_rdy && active_s;
    assign track_s     = trigger_source_rdy && ((state_r == ST_PRE) || (state_r == ST_ARMED));
    assign crossing_s  = prev_valid_r && (prev_r < value_r) && (trigger_source_in >= value_r);
    assign fire_s      = (state_r == ST_ARMED) && trigger_source_rdy && (crossing_s || timeout_s);
    assign pre_last_s  = (pre_cnt_r == (pre_len_r - ADDR_ONE));
    assign post_last_s = (post_cnt_r == (post_len_r - ADDR_ONE));

`ifdef TRIGGER_AUTO_EN
    localparam int TO_W = ($clog2(AUTO_TIMEOUT + 1) < 2) ? 2 : $clog2(AUTO_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
    localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(AUTO_TIMEOUT - 1);

    logic [TO_W-1:0] armed_cnt_r;
    logic            auto_triggered_r;

    assign timeout_s      = (armed_cnt_r == TO_LAST);
    assign auto_triggered = auto_triggered_r;

    // Armed-sample counter and forced-trigger flag, both cleared by start/stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_cnt_r      <= TO_ZERO;
            auto_triggered_r <= 1'b0;
        end else if (start || stop) begin
            armed_cnt_r      <= TO_ZERO;
            auto_triggered_r <= 1'b0;
        end else begin
            if ((state_r == ST_ARMED) && trigger_source_rdy) begin
                armed_cnt_r <= armed_cnt_r + TO_ONE;
            end
            if (fire_s && !crossing_s) begin
                auto_triggered_r <= 1'b1;
            end
        end
    end
`else
    assign timeout_s      = 1'b0;
    assign auto_triggered = 1'b0;
`endif

    // Sample-driven sequencing; stop then start override it below.
    always_comb begin
        seq_s = state_r;
        case (state_r)
            ST_IDLE: seq_s = ST_IDLE;
            ST_PRE: begin
                if (trigger_source_rdy && pre_last_s) begin
                    seq_s = ST_ARMED;
                end else begin
                    seq_s = ST_PRE;
                end
            end
            ST_ARMED: begin
                if (fire_s) begin
                    if (post_len_r == ADDR_ONE) begin
                        seq_s = ST_DONE;
                    end else begin
                        seq_s = ST_POST;
                    end
                end else begin
                    seq_s = ST_ARMED;
                end
            end
            ST_POST: begin
                if (trigger_source_rdy && post_last_s) begin
                    seq_s = ST_DONE;
                end else begin
                    seq_s = ST_POST;
                end
            end
            ST_DONE: seq_s = ST_DONE;
            default: seq_s = ST_IDLE;
        endcase
    end

    // Command override: stop wins over start.
    always_comb begin
        state_s = seq_s;
        if (stop) begin
            state_s = ST_IDLE;
        end else if (start) begin
            if (pretrigger_samples == ADDR_ZERO) begin
                state_s = ST_ARMED;
            end else begin
                state_s = ST_PRE;
            end
        end else begin
            state_s = seq_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: config latch, sample counters, write address, prev-sample tracking, trigger capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_len_r      <= ADDR_ZERO;
            post_len_r     <= ADDR_ZERO;
            pre_cnt_r      <= ADDR_ZERO;
            post_cnt_r     <= ADDR_ZERO;
            wr_addr_r      <= ADDR_ZERO;
            trigger_addr_r <= ADDR_ZERO;
            value_r        <= {BITS_ADC{1'b0}};
            prev_r         <= {BITS_ADC{1'b0}};
            prev_valid_r   <= 1'b0;
            triggered_r    <= 1'b0;
        end else if (stop) begin
            triggered_r    <= 1'b0;
        end else if (start) begin
            pre_len_r      <= pretrigger_samples;
            post_len_r     <= calc_post_len(pretrigger_samples, num_samples);
            value_r        <= trigger_value_in;
            pre_cnt_r      <= ADDR_ZERO;
            post_cnt_r     <= ADDR_ZERO;
            wr_addr_r      <= ADDR_ZERO;
            prev_valid_r   <= 1'b0;
            triggered_r    <= 1'b0;
        end else begin
            triggered_r <= fire_s;
            if (sample_s) begin
                wr_addr_r <= wr_addr_r + ADDR_ONE;
            end
            if (track_s) begin
                prev_r       <= trigger_source_in;
                prev_valid_r <= 1'b1;
            end
            if ((state_r == ST_PRE) && trigger_source_rdy) begin
                pre_cnt_r <= pre_cnt_r + ADDR_ONE;
            end
            // The trigger sample is the first post sample.
            if (fire_s) begin
                trigger_addr_r <= wr_addr_r;
                post_cnt_r     <= ADDR_ONE;
            end else if ((state_r == ST_POST) && trigger_source_rdy) begin
                post_cnt_r <= post_cnt_r + ADDR_ONE;
            end
        end
    end

    assign buffer_wr_en = sample_s;
    assign wr_addr      = wr_addr_r;
    assign trigger_addr = trigger_addr_r;
    assign triggered    = triggered_r;
    assign running      = active_s;
    assign done         = (state_r == ST_DONE);

endmodule

// File: tb/tb_trigger_edge_detector.sv
// Self-checking bench for trigger_edge_detector: randomized sample streams against a sample-index model.
module tb_trigger_edge_detector;

    localparam int TB_AUTO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [11:0] pretrigger_samples = 12'd0;
    logic [11:0] num_samples = 12'd0;
    logic [7:0]  trigger_value_in = 8'd0;
    logic [7:0]  trigger_source_in = 8'd0;
    logic        trigger_source_rdy = 1'b0;
    logic        buffer_wr_en;
    logic [11:0] wr_addr;
    logic [11:0] trigger_addr;
    logic        triggered;
    logic        auto_triggered;
    logic        running;
    logic        done;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] smp[$];

    always #5 clk = ~clk;

    trigger_edge_detector #(
        .BITS_ADC     (8),
        .BUF_ADDR_W   (12),
        .AUTO_TIMEOUT (TB_AUTO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .stop               (stop),
        .pretrigger_samples (pretrigger_samples),
        .num_samples        (num_samples),
        .trigger_value_in   (trigger_value_in),
        .trigger_source_in  (trigger_source_in),
        .trigger_source_rdy (trigger_source_rdy),
        .buffer_wr_en       (buffer_wr_en),
        .wr_addr            (wr_addr),
        .trigger_addr       (trigger_addr),
        .triggered          (triggered),
        .auto_triggered     (auto_triggered),
        .running            (running),
        .done               (done)
    );

    // Issue a start pulse at a negedge; returns at the negedge after it was sampled.
    task automatic do_start(input int pre, input int num, input int value);
        trigger_source_rdy = 1'b0;
        pretrigger_samples = 12'(pre);
        num_samples        = 12'(num);
        trigger_value_in   = 8'(value);
        start              = 1'b1;
        @(negedge clk);
        start              = 1'b0;
    endtask

    task automatic do_stop();
        trigger_source_rdy = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({buffer_wr_en, wr_addr, trigger_addr, triggered, auto_triggered, running, done} !== 29'd0) begin
            nerr++;
            $display("FAIL reset_async outputs: got %h expected 0",
                     {buffer_wr_en, wr_addr, trigger_addr, triggered, auto_triggered, running, done});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        trigger_source_rdy = 1'b1;
        @(negedge clk);
        nvec++;
        if ({buffer_wr_en, running, done, triggered} !== 4'b0000) begin
            nerr++;
            $display("FAIL reset_idle wr_en/running/done/trig: got %b expected 0000",
                     {buffer_wr_en, running, done, triggered});
        end
        trigger_source_rdy = 1'b0;
    endtask

    // kind: 0 ramp, 1 random, 2 {90,10,80} then ramp, 3 constant zero; gap 0 = random rdy.
    task automatic test_acquisition(input string name, input int pre, input int num, input int value,
                                    input int gap, input int kind, input int len);
        logic [7:0] head[3] = '{8'h90, 8'h10, 8'h80};
        int  trig, last, ne, post, n, cyc, budget;
        bit  forced, fin, rdy_b, exp_run, exp_wr, exp_trig, exp_auto;
        smp.delete();
        for (int i = 0; i < len; i++) begin
            case (kind)
                0:       smp.push_back(8'(i));
                1:       smp.push_back(8'($urandom_range(0, 255)));
                2:       smp.push_back((i < 3) ? head[i] : 8'(i));
                default: smp.push_back(8'h00);
            endcase
        end
        // Reference: the first armed sample that crosses (or times out) is the trigger.
        trig = -1;
        forced = 1'b0;
        for (int i = pre; i < len; i++) begin
            if (i >= 1 && int'(smp[i-1]) < value && int'(smp[i]) >= value) begin
                trig = i;
                break;
            end
`ifdef TRIGGER_AUTO_EN
            if (i - pre + 1 == TB_AUTO) begin
                trig = i;
                forced = 1'b1;
                break;
            end
`endif
        end
        ne   = (num == 0) ? 1 : num;
        post = (ne > pre) ? ne - pre : 1;
        last = (trig >= 0) ? trig + post - 1 : -1;
        if (trig >= 0) begin
            while (smp.size() <= last) smp.push_back(8'($urandom_range(0, 255)));
        end

        do_start(pre, num, value);
        nvec++;
        if ({running, done, triggered} !== 3'b100) begin
            nerr++;
            $display("FAIL %s start running/done/trig: got %b expected 100", name, {running, done, triggered});
        end

        n = 0;
        cyc = 0;
        fin = 1'b0;
        budget = (smp.size() + 20) * 8;
        while (!fin && cyc < budget) begin
            rdy_b = (gap == 0) ? ($urandom_range(0, 1) == 1) : ((cyc % gap) == (gap - 1));
            trigger_source_rdy = rdy_b;
            trigger_source_in  = (n < smp.size()) ? smp[n] : 8'h00;
            pretrigger_samples = 12'($urandom_range(0, 4095));
            num_samples        = 12'($urandom_range(0, 4095));
            #1;
            exp_run = (trig < 0) || (n <= last);
            exp_wr  = rdy_b && exp_run;
            nvec++;
            if (buffer_wr_en !== exp_wr) begin
                nerr++;
                $display("FAIL %s wr_en at sample %0d: got %b expected %b", name, n, buffer_wr_en, exp_wr);
            end
            if (exp_wr) begin
                nvec++;
                if (wr_addr !== 12'(n)) begin
                    nerr++;
                    $display("FAIL %s wr_addr at sample %0d: got %h expected %h", name, n, wr_addr, 12'(n));
                end
            end
            @(posedge clk);
            @(negedge clk);
            exp_trig = exp_wr && (n == trig);
            if (exp_wr) n++;
            nvec++;
            if (triggered !== exp_trig) begin
                nerr++;
                $display("FAIL %s triggered after sample %0d: got %b expected %b", name, n, triggered, exp_trig);
            end
            nvec++;
            if ({running, done} !== {(trig < 0) || (n <= last), (trig >= 0) && (n > last)}) begin
                nerr++;
                $display("FAIL %s running/done after %0d samples: got %b%b expected %b%b", name, n,
                         running, done, (trig < 0) || (n <= last), (trig >= 0) && (n > last));
            end
            exp_auto = forced && (n > trig);
            nvec++;
            if (auto_triggered !== exp_auto) begin
                nerr++;
                $display("FAIL %s auto_triggered: got %b expected %b", name, auto_triggered, exp_auto);
            end
            if (trig >= 0 && n > trig) begin
                nvec++;
                if (trigger_addr !== 12'(trig)) begin
                    nerr++;
                    $display("FAIL %s trigger_addr: got %h expected %h", name, trigger_addr, 12'(trig));
                end
            end
            if (trig >= 0 && n > last) begin
                trigger_source_rdy = 1'b1;
                #1;
                nvec++;
                if ({buffer_wr_en, wr_addr} !== {1'b0, 12'(last + 1)}) begin
                    nerr++;
                    $display("FAIL %s done_hold wr_en/addr: got %b/%h expected 0/%h", name,
                             buffer_wr_en, wr_addr, 12'(last + 1));
                end
                fin = 1'b1;
            end else if (trig < 0 && n >= len) begin
                fin = 1'b1;
            end
            cyc++;
        end
        if (!fin) begin
            nvec++;
            nerr++;
            $display("FAIL %s cycle budget expired at sample %0d of %0d", name, n, smp.size());
        end
        do_stop();
        nvec++;
        if ({running, done, auto_triggered} !== 3'b000) begin
            nerr++;
            $display("FAIL %s after stop running/done/auto: got %b expected 000", name,
                     {running, done, auto_triggered});
        end
    endtask

    task automatic test_start_stop();
        trigger_source_rdy = 1'b1;
        trigger_source_in  = 8'h00;
        pretrigger_samples = 12'd0;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        nvec++;
        if ({running, done, buffer_wr_en} !== 3'b000) begin
            nerr++;
            $display("FAIL start_stop_same running/done/wr_en: got %b expected 000", {running, done, buffer_wr_en});
        end
        do_start(0, 5, 8'h80);
        trigger_source_rdy = 1'b1;
        trigger_source_in  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nvec++;
            if ({running, buffer_wr_en, wr_addr} !== {2'b11, 12'(i + 1)}) begin
                nerr++;
                $display("FAIL stop_armed pre-stop run/wr_en/addr: got %b%b/%h expected 11/%h",
                         running, buffer_wr_en, wr_addr, 12'(i + 1));
            end
        end
        do_stop();
        trigger_source_rdy = 1'b1;
        #1;
        nvec++;
        if ({running, done, buffer_wr_en, triggered} !== 4'b0000) begin
            nerr++;
            $display("FAIL stop_armed running/done/wr_en/trig: got %b expected 0000",
                     {running, done, buffer_wr_en, triggered});
        end
        trigger_source_rdy = 1'b0;
    endtask

    task automatic test_reset_mid_post();
        do_start(2, 50, 8'h05);
        for (int i = 0; i < 8; i++) begin
            trigger_source_rdy = 1'b1;
            trigger_source_in  = 8'(i);
            @(negedge clk);
        end
        nvec++;
        if ({running, done, trigger_addr} !== {2'b10, 12'h005}) begin
            nerr++;
            $display("FAIL mid_post running/done/trig_addr: got %b%b/%h expected 10/005", running, done, trigger_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({buffer_wr_en, wr_addr, trigger_addr, triggered, auto_triggered, running, done} !== 29'd0) begin
            nerr++;
            $display("FAIL reset_mid_post outputs: got %h expected 0",
                     {buffer_wr_en, wr_addr, trigger_addr, triggered, auto_triggered, running, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nvec++;
            if ({running, done, buffer_wr_en} !== 3'b000) begin
                nerr++;
                $display("FAIL post_reset_idle running/done/wr_en: got %b expected 000", {running, done, buffer_wr_en});
            end
        end
        do_start(1, 4, 8'h80);
        nvec++;
        if (running !== 1'b1) begin
            nerr++;
            $display("FAIL post_reset_start running: got %b expected 1", running);
        end
        do_stop();
    endtask

    initial begin
        #2;
        test_reset();
        test_acquisition("ramp", 4, 10, 8'h80, 1, 0, 300);
        test_acquisition("ramp_gap3", 4, 10, 8'h80, 3, 0, 300);
        test_acquisition("pre_zero", 0, 3, 8'h80, 1, 2, 20);
        test_start_stop();
        test_acquisition("num_zero", 3, 0, 8'h40, 2, 1, 300);
        test_acquisition("pre_gt_num", 20, 5, 8'h40, 0, 1, 300);
        for (int k = 0; k < 6; k++) begin
            test_acquisition("random", $urandom_range(0, 20), $urandom_range(0, 40),
                             $urandom_range(1, 255), $urandom_range(0, 3), 1, 300);
        end
        test_acquisition("const_zero", 3, 8, 8'h80, 1, 3, 10000);
        test_reset_mid_post();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
